// File: rtl/div_if.sv
// rtl/div_if.sv - request/response bundle between the EX stage and the divider
//
// Signals:
//   signed_div_i  1   1 = signed divide, 0 = unsigned; sampled with start_i
//   opdata1_i     32  dividend; sampled with start_i
//   opdata2_i     32  divisor; sampled with start_i
//   start_i       1   request, held high until ready_o is seen
//   annul_i       1   abort an in-flight division (pipeline flush)
//   result_o      64  {remainder, quotient}
//   ready_o       1   result_o valid
//
// Modports:
//   master  EX-stage side (drives the request, reads the result)
//   slave   divider side
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div.sv
// rtl/div.sv - 32-bit signed/unsigned restoring divider, one quotient bit per cycle
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   div_if.slave: request (signed_div_i, opdata1_i, opdata2_i, start_i,
//         annul_i) and registered response (result_o = {rem, quot}, ready_o)
//
// States: FREE (idle), BYZERO (zero divisor), ON (32 shift-subtract steps),
// END (result held while start_i stays high).
module div (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_d;

    logic [5:0]  cnt_r;
    logic        signed_r;
    logic        neg1_r;
    logic        neg2_r;
    logic [31:0] dvd_r;     // dividend magnitude; shifts out MSB-first, quotient bits shift in
    logic [31:0] dvs_r;     // divisor magnitude
    logic [31:0] rem_r;     // partial remainder
    logic [63:0] result_r;
    logic        ready_r;

    logic [63:0] result_d;
    logic        ready_d;

    // Operand magnitudes at the start edge
    logic        op1_neg;
    logic        op2_neg;
    logic [31:0] mag1;
    logic [31:0] mag2;

    assign op1_neg = bus.signed_div_i & bus.opdata1_i[31];
    assign op2_neg = bus.signed_div_i & bus.opdata2_i[31];
    assign mag1    = op1_neg ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
    assign mag2    = op2_neg ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;

    logic        accept;
    assign accept = bus.start_i & ~bus.annul_i;

    // One restoring step. rem_r < dvs_r, so the shifted value fits in 33 bits;
    // a 33-bit subtract sets bit 32 exactly when the shifted value is below the divisor.
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        take;
    logic [31:0] rem_step;
    logic [31:0] dvd_step;

    assign shifted  = {rem_r, dvd_r[31]};
    assign diff     = shifted - {1'b0, dvs_r};
    assign take     = ~diff[32];
    assign rem_step = take ? diff[31:0] : shifted[31:0];
    assign dvd_step = {dvd_r[30:0], take};

    // Sign correction once all 32 steps are done
    logic        steps_done;
    logic [31:0] quot_fin;
    logic [31:0] rem_fin;

    assign steps_done = (cnt_r == 6'd32);
    assign quot_fin   = (signed_r & (neg1_r ^ neg2_r)) ? (32'd0 - dvd_r) : dvd_r;
    assign rem_fin    = (signed_r & neg1_r) ? (32'd0 - rem_r) : rem_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FREE;
        end else begin
            state_r <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_r;
        case (state_r)
            FREE: begin
                if (accept) begin
                    state_d = (bus.opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: state_d = END;
            ON: begin
                if (bus.annul_i) begin
                    state_d = FREE;
                end else if (steps_done) begin
                    state_d = END;
                end
            end
            END: begin
                if (!bus.start_i) begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        ready_d  = 1'b0;
        result_d = 64'd0;
        if (state_d == END) begin
            ready_d = 1'b1;
            case (state_r)
                ON:      result_d = {rem_fin, quot_fin};
                END:     result_d = result_r;
                default: result_d = 64'd0;   // BYZERO completes with zero
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= 6'd0;
            signed_r <= 1'b0;
            neg1_r   <= 1'b0;
            neg2_r   <= 1'b0;
            dvd_r    <= 32'd0;
            dvs_r    <= 32'd0;
            rem_r    <= 32'd0;
            result_r <= 64'd0;
            ready_r  <= 1'b0;
        end else begin
            result_r <= result_d;
            ready_r  <= ready_d;
            case (state_r)
                FREE: begin
                    if (accept && bus.opdata2_i != 32'd0) begin
                        cnt_r    <= 6'd0;
                        signed_r <= bus.signed_div_i;
                        neg1_r   <= op1_neg;
                        neg2_r   <= op2_neg;
                        dvd_r    <= mag1;
                        dvs_r    <= mag2;
                        rem_r    <= 32'd0;
                    end
                end
                ON: begin
                    if (bus.annul_i) begin
                        cnt_r <= 6'd0;
                        dvd_r <= 32'd0;
                        rem_r <= 32'd0;
                    end else if (!steps_done) begin
                        cnt_r <= cnt_r + 6'd1;
                        dvd_r <= dvd_step;
                        rem_r <= rem_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;
endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed self-checking bench for div
module tb_div;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    div_if bus();

    div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start a division, count edges to ready_o, check latency and result.
    // Leaves start_i high so the divider sits in END.
    task automatic do_div(input string tag, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [63:0] exp_res, input bit scramble);
        int n;
        bus.signed_div_i = sd;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            edge1();
            n++;
            if (bus.ready_o === 1'b1) break;
            if (scramble) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~bus.signed_div_i;
            end
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_res"}, bus.result_o, exp_res);
    endtask

    task automatic drop_start(input string tag);
        bus.start_i = 1'b0;
        edge1();
        check({tag, "_drop_rdy"}, 64'(bus.ready_o), 64'd0);
        check({tag, "_drop_res"}, bus.result_o, 64'd0);
    endtask

    initial begin
        bit seen;
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;    // ignored while in reset
        bus.annul_i      = 1'b0;
        @(negedge clk);
        edge1();
        edge1();
        check("reset_rdy", 64'(bus.ready_o), 64'd0);
        check("reset_res", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        edge1();
        rst = 1'b0;
        edge1();
        check("idle_rdy", 64'(bus.ready_o), 64'd0);

        // Unsigned 100 / 7 -> q 14, r 2
        do_div("u100_7", 1'b0, 32'd100, 32'd7, 34, {32'h2, 32'hE}, 1'b0);
        drop_start("u100_7");

        // Signed -7 / 2 -> q -3, r -1
        do_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 34, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
        drop_start("s_m7_2");

        // Signed 7 / -2 -> q -3, r 1
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 34, {32'h1, 32'hFFFFFFFD}, 1'b0);
        drop_start("s_7_m2");

        // 0xFFFFFFFF / 2 unsigned -> q 0x7FFFFFFF, r 1; signed (-1/2) -> q 0, r -1
        do_div("u_ff_2", 1'b0, 32'hFFFFFFFF, 32'd2, 34, {32'h1, 32'h7FFFFFFF}, 1'b0);
        drop_start("u_ff_2");
        do_div("s_ff_2", 1'b1, 32'hFFFFFFFF, 32'd2, 34, {32'hFFFFFFFF, 32'h0}, 1'b0);
        drop_start("s_ff_2");

        // Divide by zero
        do_div("dz", 1'b0, 32'h12345678, 32'd0, 2, 64'd0, 1'b0);
        drop_start("dz");

        // Annul at step 10 of 0xFFFFFFFF / 1
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'hFFFFFFFF;
        bus.opdata2_i    = 32'd1;
        bus.start_i      = 1'b1;
        for (int i = 0; i < 11; i++) edge1();
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        edge1();
        bus.annul_i = 1'b0;
        check("annul_rdy", 64'(bus.ready_o), 64'd0);
        check("annul_res", bus.result_o, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            edge1();
            if (bus.ready_o !== 1'b0) seen = 1'b1;
        end
        check("annul_never_rdy", 64'(seen), 64'd0);
        do_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'd1, 34, {32'h0, 32'hFFFFFFFF}, 1'b0);
        drop_start("after_annul");

        // Reset at step 20
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        for (int i = 0; i < 21; i++) edge1();
        rst = 1'b1;
        bus.start_i = 1'b0;
        edge1();
        check("rst_mid_rdy", 64'(bus.ready_o), 64'd0);
        check("rst_mid_res", bus.result_o, 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            edge1();
            if (bus.ready_o !== 1'b0) seen = 1'b1;
        end
        check("rst_no_resume", 64'(seen), 64'd0);
        do_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, {32'h0, 32'h80000000}, 1'b0);
        drop_start("s_min_m1");

        // Operands scrambled during ON: 1000 / 3 -> q 333, r 1
        do_div("scramble", 1'b0, 32'd1000, 32'd3, 34, {32'h1, 32'h14D}, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.annul_i = (i == 2);     // ignored in END
            edge1();
            check("hold_rdy", 64'(bus.ready_o), 64'd1);
            check("hold_res", bus.result_o, {32'h1, 32'h14D});
        end
        bus.annul_i = 1'b0;
        drop_start("scramble");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
